// File: rtl/vc_router_pkg.sv
// rtl/vc_router_pkg.sv - shared flit/VC types and default sizing for the router input stage
package vc_router_pkg;

  localparam int FLIT_TYPEW  = 2;
  localparam int DEF_NUM_VCS = 4;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [FLIT_TYPEW-1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } vc_state_t;

  // A flit opens a packet at the front of a VC when it is a HEAD or HEADTAIL
  function automatic logic is_head_type(input logic [FLIT_TYPEW-1:0] t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/input_vc_buffer_if.sv
// rtl/input_vc_buffer_if.sv - link, dequeue, output and status bundle of the input VC buffer
interface input_vc_buffer_if
  import vc_router_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int NUM_VCS = DEF_NUM_VCS
) ();

  localparam int VCW = $clog2(NUM_VCS);

  logic                  in_valid;
  logic [VCW-1:0]        in_vc_id;
  logic [FLIT_TYPEW-1:0] in_flit_type;
  logic [DATAW-1:0]      in_data;
  logic                  rd_en;
  logic [VCW-1:0]        rd_vc_id;

  logic                  out_valid;
  logic [VCW-1:0]        out_vc_id;
  logic [FLIT_TYPEW-1:0] out_flit_type;
  logic [DATAW-1:0]      out_data;
  logic                  credit_valid;
  logic [VCW-1:0]        credit_vc_id;
  logic [NUM_VCS-1:0]    vc_empty;
  logic [NUM_VCS-1:0]    vc_full;
  logic [NUM_VCS-1:0]    vc_active;
  logic [NUM_VCS-1:0]    front_is_head;
  logic                  overflow_err;

  modport master (
    output in_valid, in_vc_id, in_flit_type, in_data, rd_en, rd_vc_id,
    input  out_valid, out_vc_id, out_flit_type, out_data, credit_valid, credit_vc_id,
    input  vc_empty, vc_full, vc_active, front_is_head, overflow_err
  );

  modport slave (
    input  in_valid, in_vc_id, in_flit_type, in_data, rd_en, rd_vc_id,
    output out_valid, out_vc_id, out_flit_type, out_data, credit_valid, credit_vc_id,
    output vc_empty, vc_full, vc_active, front_is_head, overflow_err
  );

endinterface

// File: rtl/input_vc_buffer_fifo.sv
// rtl/input_vc_buffer_fifo.sv - single-VC circular flit FIFO (vc_fifo)
module vc_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] front_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign front_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when a pop frees the slot in the same cycle
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointers wrap on their natural width; count tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until covered by count
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/input_vc_buffer.sv
// rtl/input_vc_buffer.sv - per-input-port VC flit buffer with credit return and packet state
module input_vc_buffer
  import vc_router_pkg::*;
#(
  parameter int DATAW   = 32,
  parameter int NUM_VCS = DEF_NUM_VCS,
  parameter int DEPTH   = DEF_DEPTH
) (
  input logic               clk,
  input logic               reset,
  input_vc_buffer_if.slave  bus
);

  localparam int VCW = $clog2(NUM_VCS);
  localparam int FW  = FLIT_TYPEW + DATAW;

  logic [NUM_VCS-1:0] push, pop, empty, full, active, head;
  logic [FW-1:0]      front [NUM_VCS];
  logic [FW-1:0]      rd_front;
  flit_type_t         rd_type;
  logic               pop_any, wr_drop;

  vc_state_t             state_q [NUM_VCS];
  logic                  out_valid_q, credit_valid_q, overflow_q;
  logic [VCW-1:0]        out_vc_q, credit_vc_q;
  logic [FLIT_TYPEW-1:0] out_type_q;
  logic [DATAW-1:0]      out_data_q;

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign push[v] = bus.in_valid && (bus.in_vc_id == VCW'(v));
    assign pop[v]  = bus.rd_en && (bus.rd_vc_id == VCW'(v)) && !empty[v];

    vc_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[v]),
      .pop_i   (pop[v]),
      .wdata_i ({bus.in_flit_type, bus.in_data}),
      .front_o (front[v]),
      .empty_o (empty[v]),
      .full_o  (full[v])
    );

    assign head[v]   = !empty[v] && is_head_type(front[v][FW-1 -: FLIT_TYPEW]);
    assign active[v] = (state_q[v] == ACTIVE);
  end

  assign rd_front = front[bus.rd_vc_id];
  assign rd_type  = flit_type_t'(rd_front[FW-1 -: FLIT_TYPEW]);
  assign pop_any  = |pop;
  assign wr_drop  = bus.in_valid && full[bus.in_vc_id] && !pop[bus.in_vc_id];

  // Register the dequeued flit and the matching upstream credit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q    <= 1'b0;
      out_vc_q       <= '0;
      out_type_q     <= '0;
      out_data_q     <= '0;
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else if (pop_any) begin
      out_valid_q    <= 1'b1;
      out_vc_q       <= bus.rd_vc_id;
      out_type_q     <= rd_front[FW-1 -: FLIT_TYPEW];
      out_data_q     <= rd_front[DATAW-1:0];
      credit_valid_q <= 1'b1;
      credit_vc_q    <= bus.rd_vc_id;
    end else begin
      out_valid_q    <= 1'b0;
      credit_valid_q <= 1'b0;
    end
  end

  // Per-VC packet FSM driven by the type of each dequeued flit; malformed sequences leave state alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VCS; i++) state_q[i] <= IDLE;
    end else if (pop_any) begin
      case (state_q[bus.rd_vc_id])
        IDLE:    if (rd_type == HEAD) state_q[bus.rd_vc_id] <= ACTIVE;
        ACTIVE:  if (rd_type == TAIL) state_q[bus.rd_vc_id] <= IDLE;
        default: state_q[bus.rd_vc_id] <= IDLE;
      endcase
    end
  end

  // Sticky record of any dropped write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow_q <= 1'b0;
    else if (wr_drop) overflow_q <= 1'b1;
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_vc_id     = out_vc_q;
  assign bus.out_flit_type = out_type_q;
  assign bus.out_data      = out_data_q;
  assign bus.credit_valid  = credit_valid_q;
  assign bus.credit_vc_id  = credit_vc_q;
  assign bus.vc_empty      = empty;
  assign bus.vc_full       = full;
  assign bus.vc_active     = active;
  assign bus.front_is_head = head;
  assign bus.overflow_err  = overflow_q;

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb/tb_input_vc_buffer.sv - self-checking bench for input_vc_buffer
module tb_input_vc_buffer;
  import vc_router_pkg::*;

  localparam int NV = 4;
  localparam int DP = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  input_vc_buffer_if #(.DATAW(32), .NUM_VCS(NV)) bus ();

  input_vc_buffer #(.DATAW(32), .NUM_VCS(NV), .DEPTH(DP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: one queue per VC, a packet-open flag per VC, sticky overflow
  logic [33:0] mq [NV][$];
  bit          mact [NV];
  bit          movf;
  bit          m_ov, m_cv;
  logic [1:0]  m_ovc, m_otype, m_cvc;
  logic [31:0] m_odata;
  logic [33:0] f;
  int          r, w;
  bit          ok;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NV; v++) begin
        mq[v].delete();
        mact[v] = 0;
      end
      movf = 0; m_ov = 0; m_cv = 0;
      m_ovc = 0; m_otype = 0; m_odata = 0; m_cvc = 0;
    end else begin
      m_ov = 0;
      m_cv = 0;
      r = int'(bus.rd_vc_id);
      w = int'(bus.in_vc_id);
      if (bus.rd_en && mq[r].size() > 0) begin
        f = mq[r].pop_front();
        m_ov = 1; m_ovc = bus.rd_vc_id; m_otype = f[33:32]; m_odata = f[31:0];
        m_cv = 1; m_cvc = bus.rd_vc_id;
        ok = 1;
        case (f[33:32])
          2'b00: begin ok = !mact[r]; mact[r] = 1; end
          2'b01: ok = mact[r];
          2'b10: begin ok = mact[r]; mact[r] = 0; end
          default: ok = !mact[r];
        endcase
        assert (ok) else $warning("protocol violation on vc %0d", r);
      end
      if (bus.in_valid) begin
        if (mq[w].size() < DP) mq[w].push_back({bus.in_flit_type, bus.in_data});
        else movf = 1;
      end
    end
  end

  // Compare process: every cycle out of reset, away from the active edge
  always @(negedge clk) begin
    logic [NV-1:0] e_empty, e_full, e_act, e_head;
    if (reset) begin
      for (int v = 0; v < NV; v++) begin
        e_empty[v] = (mq[v].size() == 0);
        e_full[v]  = (mq[v].size() == DP);
        e_act[v]   = mact[v];
        e_head[v]  = (mq[v].size() > 0) && (mq[v][0][33:32] == 2'b00 || mq[v][0][33:32] == 2'b11);
      end
      chk("out_valid", bus.out_valid, m_ov);
      chk("out_data", bus.out_data, m_odata);
      chk("out_vc_id", bus.out_vc_id, m_ovc);
      chk("out_flit_type", bus.out_flit_type, m_otype);
      chk("credit_valid", bus.credit_valid, m_cv);
      if (m_cv) chk("credit_vc_id", bus.credit_vc_id, m_cvc);
      chk("vc_empty", bus.vc_empty, e_empty);
      chk("vc_full", bus.vc_full, e_full);
      chk("vc_active", bus.vc_active, e_act);
      chk("front_is_head", bus.front_is_head, e_head);
      chk("overflow_err", bus.overflow_err, movf);
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge with inputs idle
  task automatic cyc(input bit iv, input logic [1:0] vc, input logic [1:0] ty,
                     input logic [31:0] d, input bit re, input logic [1:0] rvc);
    bus.in_valid = iv; bus.in_vc_id = vc; bus.in_flit_type = ty; bus.in_data = d;
    bus.rd_en = re; bus.rd_vc_id = rvc;
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.rd_en = 0;
  endtask

  task automatic wr(input logic [1:0] vc, input logic [1:0] ty, input logic [31:0] d);
    cyc(1, vc, ty, d, 0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] vc);
    cyc(0, 2'd0, 2'd0, 32'd0, 1, vc);
  endtask

  logic [31:0] exp_d [4];

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0;
    bus.in_valid = 0; bus.in_vc_id = 0; bus.in_flit_type = 0; bus.in_data = 0;
    bus.rd_en = 0; bus.rd_vc_id = 0;
    #12 reset = 1'b1;
    #1;
    chk("rst_vc_empty", bus.vc_empty, 4'b1111);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_credit_valid", bus.credit_valid, 0);
    chk("rst_overflow", bus.overflow_err, 0);
    chk("rst_out_data", bus.out_data, 0);

    // Single packet on VC2
    wr(2, HEAD, 32'hA);
    chk("pkt_front_head", bus.front_is_head[2], 1);
    wr(2, BODY, 32'hB);
    wr(2, TAIL, 32'hC);
    rd(2);
    chk("pkt_a_valid", bus.out_valid, 1);
    chk("pkt_a_data", bus.out_data, 32'hA);
    chk("pkt_a_vc", bus.out_vc_id, 2);
    chk("pkt_a_credit", {bus.credit_valid, bus.credit_vc_id}, 3'b110);
    chk("pkt_active_set", bus.vc_active[2], 1);
    rd(2);
    chk("pkt_b_data", bus.out_data, 32'hB);
    rd(2);
    chk("pkt_c_data", bus.out_data, 32'hC);
    chk("pkt_c_credit", {bus.credit_valid, bus.credit_vc_id}, 3'b110);
    chk("pkt_active_clr", bus.vc_active[2], 0);

    // Overflow on VC1
    wr(1, HEAD, 32'h11);
    wr(1, BODY, 32'h12);
    wr(1, BODY, 32'h13);
    wr(1, TAIL, 32'h14);
    chk("ovf_full", bus.vc_full[1], 1);
    chk("ovf_not_yet", bus.overflow_err, 0);
    wr(1, BODY, 32'h15);
    chk("ovf_set", bus.overflow_err, 1);
    for (int i = 0; i < 4; i++) begin
      rd(1);
      chk("ovf_drain", bus.out_data, 32'h11 + i);
    end
    rd(1);
    chk("ovf_drain_empty", bus.out_valid, 0);

    // Full VC0 with simultaneous read and write
    wr(0, HEAD, 32'h01);
    wr(0, BODY, 32'h02);
    wr(0, BODY, 32'h03);
    wr(0, BODY, 32'h04);
    cyc(1, 0, TAIL, 32'h55, 1, 0);
    chk("fullrw_data", bus.out_data, 32'h01);
    chk("fullrw_still_full", bus.vc_full[0], 1);
    exp_d[0] = 32'h02; exp_d[1] = 32'h03; exp_d[2] = 32'h04; exp_d[3] = 32'h55;
    for (int i = 0; i < 4; i++) begin
      rd(0);
      chk("fullrw_drain", bus.out_data, exp_d[i]);
    end
    chk("overflow_sticky", bus.overflow_err, 1);

    // Empty VC3 reads, no bypass
    rd(3);
    chk("empty_rd_valid", bus.out_valid, 0);
    chk("empty_rd_credit", bus.credit_valid, 0);
    cyc(1, 3, HEADTAIL, 32'h33, 1, 3);
    chk("no_bypass_valid", bus.out_valid, 0);
    rd(3);
    chk("ht_data", bus.out_data, 32'h33);
    chk("ht_credit", {bus.credit_valid, bus.credit_vc_id}, 3'b111);
    chk("ht_idle", bus.vc_active[3], 0);

    // Interleaved VC0/VC1 traffic; pointers wrap
    for (int i = 0; i < 10; i++)
      cyc(1, 2'(i % 2), HEADTAIL, 32'h100 + i, i >= 2, 2'(i % 2));
    rd(0);
    chk("ilv_vc0_last", bus.out_data, 32'h108);
    rd(1);
    chk("ilv_vc1_last", bus.out_data, 32'h109);

    // Async reset mid-packet on VC2
    wr(2, HEAD, 32'h21);
    wr(2, BODY, 32'h22);
    wr(2, BODY, 32'h23);
    rd(2);
    chk("mid_active", bus.vc_active[2], 1);
    chk("mid_valid", bus.out_valid, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_credit", bus.credit_valid, 0);
    chk("arst_empty", bus.vc_empty[2], 1);
    chk("arst_active", bus.vc_active[2], 0);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_credit", bus.credit_valid, 0);
    chk("post_rst_ovf", bus.overflow_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
Name: input_vc_buffer

Overview:
- Per-input-port virtual-channel flit buffer for the router.
- Accepts flits from the link, stores each in a per-VC FIFO and issues credits upstream on dequeue.
- Presents the selected VC's front flit, one cycle after a read request, to the downstream stage-boundary pipe_register that feeds switch traversal.
- Tracks per-VC packet state (idle / active) for the VC and switch allocators.

Parameters:
- DATAW, 32, flit payload width in bits.
- NUM_VCS, 4, virtual channels per input port (power of 2, ≥2).
- DEPTH, 4, flit slots per VC (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  flit present on link this cycle.
- in_vc_id  in  $clog2(NUM_VCS)  target VC of incoming flit.
- in_flit_type  in  2  HEAD=00, BODY=01, TAIL=10, HEADTAIL=11.
- in_data  in  DATAW  flit payload.
- rd_en  in  1  dequeue request from switch allocator.
- rd_vc_id  in  $clog2(NUM_VCS)  VC to dequeue.
- out_valid  out  1  registered flit valid.
- out_vc_id  out  $clog2(NUM_VCS)  VC of output flit.
- out_flit_type  out  2  type of output flit.
- out_data  out  DATAW  output payload.
- credit_valid  out  1  one credit returned upstream.
- credit_vc_id  out  $clog2(NUM_VCS)  VC of returned credit.
- vc_empty  out  NUM_VCS  per-VC empty flag.
- vc_full  out  NUM_VCS  per-VC full flag.
- vc_active  out  NUM_VCS  per-VC packet-in-progress flag.
- front_is_head  out  NUM_VCS  front flit of VC is HEAD or HEADTAIL and VC is non-empty.
- overflow_err  out  1  sticky: write to a full VC was dropped.

Behaviour:
- Reset (reset=0, async):
  - All pointers and counts are 0.
  - vc_empty all 1; vc_full, vc_active and front_is_head all 0.
  - out_valid, credit_valid and overflow_err are 0.
  - out_data, out_vc_id and out_flit_type are 0.
  - A reset mid-packet discards all stored flits; no credits are issued for them.
- Storage: each VC has a circular FIFO with rd_ptr/wr_ptr of $clog2(DEPTH) bits that wrap naturally, plus a count of $clog2(DEPTH)+1 bits.
- Flags: vc_empty = (count==0); vc_full = (count==DEPTH). Both are combinational from registered counts.
- Write: on in_valid, store {in_flit_type, in_data} at wr_ptr of in_vc_id; the flit is visible to reads the following cycle.
- Write when full:
  - Dropped, overflow_err set (it clears only on reset).
  - Exception: if rd_en targets the same VC in the same cycle, the write is accepted and the count is unchanged.
- Read:
  - Takes effect only if rd_vc_id is non-empty at the clock edge.
  - The front flit is registered to out_* next cycle with out_valid=1, and rd_ptr advances.
  - credit_valid=1 and credit_vc_id=rd_vc_id are asserted in that same next cycle.
- Read latency: exactly 1 cycle, rd_en to out_valid. One read per cycle; back-to-back reads give out_valid continuously high.
- Read of an empty VC: ignored, no credit, out_valid=0. There is no write-to-read bypass, so a simultaneous write and read on an empty VC yields out_valid=0.
- Simultaneous read and write, same non-empty VC: both succeed and count is unchanged. Different VCs are independent.
- out_data, out_vc_id and out_flit_type hold their last value when out_valid=0.
- Per-VC FSM, states IDLE and ACTIVE:
  - IDLE→ACTIVE: a HEAD flit is dequeued.
  - ACTIVE→IDLE: a TAIL flit is dequeued.
  - HEADTAIL dequeued in IDLE: stays IDLE.
  - Protocol violations: BODY/TAIL dequeued in IDLE, or HEAD dequeued in ACTIVE, are still dequeued and leave the state unchanged. The bench flags them with an assertion.
- vc_active = (state==ACTIVE). front_is_head is combinational from the front flit's type.

Decomposition:
- Shared package vc_router_pkg:
  - typedef flit_type_t (enum HEAD/BODY/TAIL/HEADTAIL).
  - typedef vc_state_t (IDLE/ACTIVE).
  - Constants FLIT_TYPEW=2 and default NUM_VCS/DEPTH.
- Natural sub-module: vc_fifo, a single-VC circular FIFO with push/pop/count/empty/full. It is instantiated NUM_VCS times via generate.
- Top-level logic: read mux, output/credit registers, per-VC FSM, overflow flag.

Test Plan:
- Reset then idle: after reset=0→1, expect vc_empty=4'b1111, out_valid=0, credit_valid=0, overflow_err=0.
- Single packet:
  - Stimulus: write HEAD(0xA), BODY(0xB), TAIL(0xC) to VC2, then rd_en on VC2 for 3 cycles.
  - Expect out_data A,B,C on consecutive cycles, each 1 cycle after its rd_en, with out_vc_id=2 and 3 credits with credit_vc_id=2.
  - Expect vc_active[2]=1 after A is dequeued and 0 after C.
- Full/overflow:
  - Write 5 flits to VC1 (DEPTH=4): vc_full[1]=1 after 4 writes; the 5th write sets overflow_err=1.
  - Draining gives only the first 4 payloads, in order.
- Full with simultaneous read/write:
  - With VC0 full, rd_en VC0 plus a write of 0x55 to VC0 in one cycle: write accepted and vc_full[0] stays 1.
  - The 0x55 flit emerges 4th in the subsequent drain.
- Empty read and interleave:
  - rd_en on empty VC3: out_valid=0, credit_valid=0.
  - Interleaved writes to VC0/VC1 with alternating reads: per-VC order is preserved and pointers wrap after 8 cycles of traffic.
- Async reset mid-packet: with VC2 ACTIVE holding 2 flits, pulse reset low off a clock edge. Outputs clear immediately, vc_empty[2]=1, vc_active[2]=0, and no credits are issued.
